// File: rtl/uart_pkg.sv
// Shared UART receiver types and constants.
package uart_pkg;

    localparam int unsigned DATA_BITS        = 8;
    localparam int unsigned DEF_CLKS_PER_BIT = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } state_e;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous single-bit inputs, with selectable reset value.
module sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start, 8 data bits LSB first, parity, stop; 3-sample majority vote per bit.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter bit          PARITY_ODD   = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       Rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy,
    output logic [7:0] err_count
);

    localparam int unsigned HALF  = CLKS_PER_BIT / 2;
    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W = $clog2(DATA_BITS);

    logic                 rx_s;
    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_nxt;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 s0_q, s0_d, s1_q, s1_d;
    logic                 par_err_q, par_err_d;
    logic [7:0]           data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q, frame_err_d;
    logic                 busy_q, busy_d;
    logic [7:0]           err_count_q, err_count_d;
    logic                 decide;
    logic                 maj;

    sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (Rx),
        .q_o (rx_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            s0_q         <= 1'b1;
            s1_q         <= 1'b1;
            par_err_q    <= 1'b0;
            data_q       <= 8'h00;
            valid_q      <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
            err_count_q  <= 8'h00;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            s0_q         <= s0_d;
            s1_q         <= s1_d;
            par_err_q    <= par_err_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            busy_q       <= busy_d;
            err_count_q  <= err_count_d;
        end
    end

    // Bit value is the majority of the samples at HALF-1, HALF and HALF+1, decided at HALF+1.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        shift_d      = shift_q;
        par_err_d    = par_err_q;
        data_d       = data_q;
        valid_d      = 1'b0;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        err_count_d  = err_count_q;

        cnt_nxt = (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) ? '0 : cnt_q + CNT_W'(1);
        decide  = (cnt_q == CNT_W'(HALF + 1));
        maj     = (s0_q & s1_q) | (s0_q & rx_s) | (s1_q & rx_s);
        s0_d    = (cnt_q == CNT_W'(HALF - 1)) ? rx_s : s0_q;
        s1_d    = (cnt_q == CNT_W'(HALF))     ? rx_s : s1_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d = START;
                    cnt_d   = CNT_W'(1);
                end
            end
            START: begin
                cnt_d = cnt_nxt;
                if (decide) begin
                    if (maj) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        state_d = DATA;
                        idx_d   = '0;
                    end
                end
            end
            DATA: begin
                cnt_d = cnt_nxt;
                if (decide) begin
                    shift_d = {maj, shift_q[DATA_BITS-1:1]};
                    idx_d   = idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(DATA_BITS - 1)) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                cnt_d = cnt_nxt;
                if (decide) begin
                    par_err_d = maj ^ (^shift_q) ^ PARITY_ODD;
                    state_d   = STOP;
                end
            end
            STOP: begin
                cnt_d = cnt_nxt;
                if (decide) begin
                    data_d       = shift_q;
                    parity_err_d = par_err_q;
                    frame_err_d  = ~maj;
                    valid_d      = 1'b1;
                    if ((par_err_q | ~maj) && (err_count_q != 8'hFF)) begin
                        err_count_d = err_count_q + 8'd1;
                    end
                    cnt_d   = '0;
                    state_d = maj ? IDLE : BREAK;
                end
            end
            BREAK: begin
                cnt_d = '0;
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d == START) || (state_d == DATA) ||
                 (state_d == PARITY) || (state_d == STOP);
    end

    assign data       = data_q;
    assign valid      = valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign busy       = busy_q;
    assign err_count  = err_count_q;

endmodule
